// File: rtl/add_nibble_serial.sv
// add_nibble_serial: multi-cycle W-bit adder, one 4-bit slice per clock, with an optional signed-overflow flag.
// Define ADD_NIBBLE_SERIAL_OVF_EN to add output V (signed overflow of the last completed sum).
module add_nibble_serial #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [4*N-1:0] I0,
  input  logic [4*N-1:0] I1,
  input  logic         CIN,
  output logic [4*N-1:0] O,
  output logic         COUT,
  output logic         BUSY,
  output logic         DONE
`ifdef ADD_NIBBLE_SERIAL_OVF_EN
  ,
  output logic         V
`endif
);
  localparam int W  = 4 * N;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d, o_q, o_d;
  logic           carry_q, carry_d, cout_q, cout_d;
  logic [4:0]     slice;
  logic           last;
`ifdef ADD_NIBBLE_SERIAL_OVF_EN
  logic           v_q, v_d;
`endif
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    o_d     = o_q;
    cout_d  = cout_q;
`ifdef ADD_NIBBLE_SERIAL_OVF_EN
    v_d     = v_q;
`endif
    slice = {1'b0, a_q[4*k_q +: 4]} + {1'b0, b_q[4*k_q +: 4]} + {4'b0, carry_q};
    last  = k_q == KW'(N - 1);
    if (START && state_q != S_RUN) begin
      a_d     = I0;
      b_d     = I1;
      carry_d = CIN;
      k_d     = '0;
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      sum_d[4*k_q +: 4] = slice[3:0];
      carry_d = slice[4];
      k_d     = k_q + KW'(1);
      if (last) begin
        state_d = S_DONE;
        o_d     = sum_d;
        cout_d  = slice[4];
`ifdef ADD_NIBBLE_SERIAL_OVF_EN
        // carry into the MSB is recovered from the MSB sum bit and its operand bits
        v_d     = slice[4] ^ (a_q[W-1] ^ b_q[W-1] ^ slice[3]);
`endif
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      o_q     <= '0;
      cout_q  <= 1'b0;
`ifdef ADD_NIBBLE_SERIAL_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      o_q     <= o_d;
      cout_q  <= cout_d;
`ifdef ADD_NIBBLE_SERIAL_OVF_EN
      v_q     <= v_d;
`endif
    end
  end
  assign O    = o_q;
  assign COUT = cout_q;
  assign BUSY = state_q == S_RUN;
  assign DONE = state_q == S_DONE;
`ifdef ADD_NIBBLE_SERIAL_OVF_EN
  assign V    = v_q;
`endif
endmodule

// File: tb/tb_add_nibble_serial.sv
// tb_add_nibble_serial: directed scoreboard bench for add_nibble_serial (N=4, W=16).
module tb_add_nibble_serial;
  localparam int N = 4;
  localparam int W = 16;
  logic         CLK = 1'b0;
  logic         RESET, START, CIN, COUT, BUSY, DONE;
  logic [W-1:0] I0, I1, O;
`ifdef ADD_NIBBLE_SERIAL_OVF_EN
  logic         V;
`endif
  typedef struct packed {
    logic [W-1:0] o;
    logic         c;
    logic         v;
  } exp_t;
  exp_t         sb[$];
  int           done_cyc[$];
  int           errors = 0, checks = 0, done_cnt = 0, cyc = 0;
  logic [W-1:0] last_o = '0;
  logic         last_c = 1'b0;

  add_nibble_serial #(.N(N)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .I0(I0), .I1(I1), .CIN(CIN),
    .O(O), .COUT(COUT), .BUSY(BUSY), .DONE(DONE)
`ifdef ADD_NIBBLE_SERIAL_OVF_EN
    , .V(V)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    model.o = s[W-1:0];
    model.c = s[W];
    model.v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // scoreboard consumer; also checks O/COUT never move while an operation is in flight
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      last_o = '0;
      last_c = 1'b0;
    end else begin
      if (BUSY) begin
        chk("hold_o", O, last_o);
        chk("hold_cout", COUT, last_c);
      end
      if (DONE) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        chk("done_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sum_o", O, e.o);
          chk("sum_cout", COUT, e.c);
`ifdef ADD_NIBBLE_SERIAL_OVF_EN
          chk("sum_v", V, e.v);
`endif
          last_o = e.o;
          last_c = e.c;
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    I0 = a;
    I1 = b;
    CIN = c;
    sb.push_back(model(a, b, c));
    START = 1'b1;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string tag);
    int edges, busy;
    drive(a, b, c);
    @(posedge CLK);
    #1 START = 1'b0;
    edges = 1;
    busy = BUSY ? 1 : 0;
    while (!DONE && edges < 40) begin
      @(posedge CLK);
      #1 edges++;
      busy += BUSY ? 1 : 0;
    end
    chk({tag, "_latency"}, edges, N + 1);
    chk({tag, "_busy_cycles"}, busy, N);
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_zero(input string tag);
    chk({tag, "_o"}, O, 0);
    chk({tag, "_cout"}, COUT, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
`ifdef ADD_NIBBLE_SERIAL_OVF_EN
    chk({tag, "_v"}, V, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n, bound;
    RESET = 1'b1; START = 1'b0; I0 = '0; I1 = '0; CIN = 1'b0;
    #2 reset_zero("reset");
    @(negedge CLK) RESET = 1'b0;
    // first op is issued right after reset release: START taken on the first edge
    op(16'h1234, 16'h1111, 1'b0, "basic");
    op(16'hFFFF, 16'h0000, 1'b1, "ripple");
    op(16'h7FFF, 16'h0001, 1'b0, "posovf");
    op(16'h8000, 16'h8000, 1'b0, "negovf");
    op(16'h0F0F, 16'h00F1, 1'b1, "mixed");
    for (int i = 0; i < 4; i++)
      op(W'($urandom), W'($urandom), 1'($urandom_range(1)), "rand");

    // back-to-back with START held high, new operands presented during each DONE
    d0 = done_cnt;
    n = done_cyc.size();
    drive(16'h0001, 16'h0002, 1'b0);
    for (int j = 0; j < 3; j++) begin
      bound = 0;
      do begin
        @(posedge CLK);
        #1 bound++;
      end while (!DONE && bound < 40);
      chk("b2b_done_seen", DONE, 1);
      if (j == 0) begin
        sb.pop_back();
        drive(16'hABCD, 16'h5432, 1'b1);
        sb.push_front(model(16'h0001, 16'h0002, 1'b0));
      end else if (j == 1) begin
        drive(16'hC000, 16'h4000, 1'b0);
      end else begin
        START = 1'b0;
      end
    end
    @(negedge CLK);
    #1;
    chk("b2b_done_count", done_cnt - d0, 3);
    if (done_cyc.size() >= n + 3) begin
      chk("b2b_gap1", done_cyc[n+1] - done_cyc[n], N + 1);
      chk("b2b_gap2", done_cyc[n+2] - done_cyc[n+1], N + 1);
    end
    repeat (2) @(posedge CLK);
    #1;

    // START and operand changes during RUN must be ignored
    d0 = done_cnt;
    drive(16'h1357, 16'h2468, 1'b1);
    @(posedge CLK);
    #1 START = 1'b0;
    @(posedge CLK);
    #1 I0 = 16'hFFFF; I1 = 16'hFFFF; CIN = 1'b1; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    chk("ignore_done_count", done_cnt - d0, 1);
    chk("ignore_sb_empty", sb.size(), 0);

    // asynchronous reset in the middle of the second RUN cycle
    drive(16'h4444, 16'h3333, 1'b0);
    @(posedge CLK);
    #1 START = 1'b0;
    @(posedge CLK);
    #3 RESET = 1'b1;
    #1 reset_zero("midrun_reset");
    sb.delete();
    d0 = done_cnt;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    chk("midrun_no_done", done_cnt - d0, 0);
    op(16'h2222, 16'h1111, 1'b1, "after_reset");
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
